// File: rtl/display_scan_module_pkg.sv
// Shared display constants: active-low hex glyphs, blank pattern, blink phase.
package display_scan_module_pkg;

  // Segment order is {dp, g, f, e, d, c, b, a}; every glyph has dp off.
  localparam logic [7:0] SEG_HEX_0 = 8'hC0;
  localparam logic [7:0] SEG_HEX_1 = 8'hF9;
  localparam logic [7:0] SEG_HEX_2 = 8'hA4;
  localparam logic [7:0] SEG_HEX_3 = 8'hB0;
  localparam logic [7:0] SEG_HEX_4 = 8'h99;
  localparam logic [7:0] SEG_HEX_5 = 8'h92;
  localparam logic [7:0] SEG_HEX_6 = 8'h82;
  localparam logic [7:0] SEG_HEX_7 = 8'hF8;
  localparam logic [7:0] SEG_HEX_8 = 8'h80;
  localparam logic [7:0] SEG_HEX_9 = 8'h90;
  localparam logic [7:0] SEG_HEX_A = 8'h88;
  localparam logic [7:0] SEG_HEX_B = 8'h83;
  localparam logic [7:0] SEG_HEX_C = 8'hC6;
  localparam logic [7:0] SEG_HEX_D = 8'hA1;
  localparam logic [7:0] SEG_HEX_E = 8'h86;
  localparam logic [7:0] SEG_HEX_F = 8'h8E;

  // All segments and the decimal point dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // AND mask that lights the decimal point (bit 7 low).
  localparam logic [7:0] SEG_DP_MASK = 8'h7F;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } blink_phase_e;

endpackage

// File: rtl/display_scan_module_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module seg7_hex_decode
  import display_scan_module_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] glyph
);

  // Map each nibble value onto its glyph constant.
  always_comb begin
    glyph = SEG_BLANK;
    case (nibble)
      4'h0: glyph = SEG_HEX_0;
      4'h1: glyph = SEG_HEX_1;
      4'h2: glyph = SEG_HEX_2;
      4'h3: glyph = SEG_HEX_3;
      4'h4: glyph = SEG_HEX_4;
      4'h5: glyph = SEG_HEX_5;
      4'h6: glyph = SEG_HEX_6;
      4'h7: glyph = SEG_HEX_7;
      4'h8: glyph = SEG_HEX_8;
      4'h9: glyph = SEG_HEX_9;
      4'hA: glyph = SEG_HEX_A;
      4'hB: glyph = SEG_HEX_B;
      4'hC: glyph = SEG_HEX_C;
      4'hD: glyph = SEG_HEX_D;
      4'hE: glyph = SEG_HEX_E;
      4'hF: glyph = SEG_HEX_F;
      default: glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_module.sv
// Multiplexed 7-segment scanner with frame-synchronous double buffering,
// leading-zero blanking and whole-display blink.
module display_scan_module
  import display_scan_module_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int CLK_DIV      = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blink_en,
  output logic                  pending,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                pending_q, pending_d;
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  blink_phase_e        phase_q, phase_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic                tick;
  logic                boundary;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                lead_zero;
  logic [7:0]          glyph;

  assign tick     = (presc_q == PRE_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);

  // Select the current digit and decide whether it is a leading zero
  // (it and every higher digit carry neither a nonzero nibble nor a dp).
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    lead_zero = (idx_q != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        cur_nib = disp_data_q[4*i +: 4];
        cur_dp  = disp_dp_q[i];
      end
      if ((IDX_W'(i) >= idx_q) &&
          ((disp_data_q[4*i +: 4] != 4'h0) || disp_dp_q[i])) begin
        lead_zero = 1'b0;
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble (cur_nib),
    .glyph  (glyph)
  );

  // Next-state: scan timing, shadow/display buffering, blink and outputs.
  always_comb begin
    presc_d       = tick ? '0 : presc_q + 1'b1;
    idx_d         = idx_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    disp_data_d   = disp_data_q;
    disp_dp_d     = disp_dp_q;
    pending_d     = pending_q;
    blk_cnt_d     = blk_cnt_q;
    phase_d       = phase_q;
    frame_done_d  = boundary;

    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (load) begin
      shadow_data_d = data_in;
      shadow_dp_d   = dp_in;
    end

    // A load landing on the boundary bypasses the shadow so it is never
    // held back a whole extra frame.
    if (boundary && load) begin
      disp_data_d = data_in;
      disp_dp_d   = dp_in;
      pending_d   = 1'b0;
    end else if (boundary && pending_q) begin
      disp_data_d = shadow_data_q;
      disp_dp_d   = shadow_dp_q;
      pending_d   = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end

    if (boundary) begin
      blk_cnt_d = (blk_cnt_q == BLK_LAST) ? '0 : blk_cnt_q + 1'b1;
    end

    if (!blink_en) begin
      phase_d = PHASE_ON;
    end else if (boundary && (blk_cnt_q == BLK_LAST)) begin
      phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
    end

    seg_d = cur_dp ? (glyph & SEG_DP_MASK) : glyph;
    if ((blink_en && (phase_q == PHASE_OFF)) || lead_zero) begin
      an_d = '1;
    end else begin
      an_d = ~(DIGITS'(1) << idx_q);
    end
  end

  // State register; reset clears everything to a dark, idle display of 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q       <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      disp_data_q   <= '0;
      disp_dp_q     <= '0;
      pending_q     <= 1'b0;
      blk_cnt_q     <= '0;
      phase_q       <= PHASE_ON;
      seg_q         <= SEG_BLANK;
      an_q          <= '1;
      frame_done_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      disp_data_q   <= disp_data_d;
      disp_dp_q     <= disp_dp_d;
      pending_q     <= pending_d;
      blk_cnt_q     <= blk_cnt_d;
      phase_q       <= phase_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign pending    = pending_q;
  assign SEG        = seg_q;
  assign AN         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_module.sv
// Bench for display_scan_module (DIGITS=4, CLK_DIV=4, BLINK_FRAMES=2):
// a timeline-based reference model checked every cycle, plus literal checks.
module tb_display_scan_module;

  localparam int D     = 4;
  localparam int CD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = D * CD;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blink_en = 1'b0;
  logic        pending;
  logic [7:0]  SEG;
  logic [3:0]  AN;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  display_scan_module #(.DIGITS(D), .CLK_DIV(CD), .BLINK_FRAMES(BF)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load       (load),
    .blink_en   (blink_en),
    .pending    (pending),
    .SEG        (SEG),
    .AN         (AN),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model state: c = clock edges since reset release; everything about scan
  // position and frame number is derived from it arithmetically.
  typedef struct packed {
    logic [31:0] c;
    logic [15:0] sh;
    logic [3:0]  shdp;
    logic [15:0] disp;
    logic [3:0]  dispdp;
    logic        pend;
    logic        phase_on;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        fd;
  } model_t;

  model_t m;
  bit     m_valid = 0;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.phase_on = 1'b1;
    r.an       = 4'hF;
    r.seg      = 8'hFF;
    return r;
  endfunction

  function automatic model_t model_step(model_t s, logic ld, logic [15:0] din,
                                        logic [3:0] dpi, logic ben);
    model_t n;
    int     idx;
    int     frame_no;
    bit     bnd;
    logic [3:0] nib;
    n        = s;
    idx      = int'((s.c / CD) % D);
    frame_no = int'(s.c / FRAME);
    bnd      = ((s.c % FRAME) == FRAME - 1);
    nib      = s.disp[4*idx +: 4];
    if (ben && !s.phase_on)
      n.an = 4'hF;
    else if (idx > 0 && (16'(s.disp >> (4*idx)) == 16'h0) && (4'(s.dispdp >> idx) == 4'h0))
      n.an = 4'hF;
    else
      n.an = ~(4'b0001 << idx);
    n.seg = glyph_tab[nib] & (s.dispdp[idx] ? 8'h7F : 8'hFF);
    n.fd  = bnd;
    if (!ben) n.phase_on = 1'b1;
    else if (bnd && (frame_no % BF) == BF - 1) n.phase_on = !s.phase_on;
    if (bnd && ld) begin
      n.disp = din; n.dispdp = dpi; n.pend = 1'b0;
    end else if (bnd && s.pend) begin
      n.disp = s.sh; n.dispdp = s.shdp; n.pend = 1'b0;
    end else if (ld) begin
      n.pend = 1'b1;
    end
    if (ld) begin
      n.sh = din; n.shdp = dpi;
    end
    n.c = s.c + 1;
    return n;
  endfunction

  // Reference model advances on the same edges as the DUT.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m       <= model_reset();
      m_valid <= 1'b1;
    end else begin
      m <= model_step(m, load, data_in, dp_in, blink_en);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (m_valid) begin
      check("model_AN", 32'(AN), 32'(m.an));
      if (RST || m.an != 4'hF) check("model_SEG", 32'(SEG), 32'(m.seg));
      check("model_pending", 32'(pending), 32'(m.pend));
      check("model_frame_done", 32'(frame_done), 32'(m.fd));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    data_in = d;
    dp_in   = dp;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  task automatic wait_fd();
    bit seen;
    seen = 0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      step();
      if (frame_done === 1'b1) seen = 1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL wait_frame_done: timeout, got no pulse expected pulse at %0t", $time);
    end
  endtask

  logic [3:0] an_1234  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] seg_1234 [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
  logic [3:0] an_0050  [4] = '{4'hE, 4'hD, 4'hF, 4'hF};
  logic [7:0] seg_0050 [4] = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
  bit         off_frame [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and release.
    repeat (3) step();
    check("rst_AN", 32'(AN), 32'h0F);
    check("rst_SEG", 32'(SEG), 32'hFF);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    RST = 1'b0;
    #1;
    check("release_AN", 32'(AN), 32'h0F);
    check("release_SEG", 32'(SEG), 32'hFF);
    step();
    check("first_AN", 32'(AN), 32'h0E);
    check("first_SEG", 32'(SEG), 32'hC0);

    // Mid-frame load is held until the boundary, then scanned 4,3,2,1.
    repeat (5) step();
    do_load(16'h1234, 4'h0);
    check("pend_set", 32'(pending), 32'h1);
    wait_fd();
    check("pend_clear", 32'(pending), 32'h0);
    for (int j = 0; j < 4; j++) begin
      if (j == 0) step(); else repeat (CD) step();
      check("scan1234_AN", 32'(AN), 32'(an_1234[j]));
      check("scan1234_SEG", 32'(SEG), 32'(seg_1234[j]));
    end

    // Leading-zero blanking.
    do_load(16'h0050, 4'h0);
    wait_fd();
    for (int j = 0; j < 4; j++) begin
      if (j == 0) step(); else repeat (CD) step();
      check("scan0050_AN", 32'(AN), 32'(an_0050[j]));
      if (j < 2) check("scan0050_SEG", 32'(SEG), 32'(seg_0050[j]));
    end
    do_load(16'h0000, 4'h0);
    wait_fd();
    step();
    check("zero_d0_AN", 32'(AN), 32'h0E);
    check("zero_d0_SEG", 32'(SEG), 32'hC0);
    for (int j = 1; j < 4; j++) begin
      repeat (CD) step();
      check("zero_blank_AN", 32'(AN), 32'h0F);
    end

    // Last load before a boundary wins.
    wait_fd();
    do_load(16'h8888, 4'h0);
    step();
    do_load(16'hFFFF, 4'h0);
    check("lastwins_pend", 32'(pending), 32'h1);
    wait_fd();
    check("lastwins_pend_clear", 32'(pending), 32'h0);
    step();
    check("lastwins_AN", 32'(AN), 32'h0E);
    check("lastwins_SEG", 32'(SEG), 32'h8E);

    // Load exactly on the boundary bypasses a pending shadow value.
    do_load(16'h1111, 4'h0);
    repeat (13) step();
    do_load(16'h5A3C, 4'h0);
    check("bypass_pend", 32'(pending), 32'h0);
    check("bypass_fd", 32'(frame_done), 32'h1);
    step();
    check("bypass_d0_SEG", 32'(SEG), 32'hC6);
    repeat (CD) step();
    check("bypass_d1_AN", 32'(AN), 32'h0D);
    check("bypass_d1_SEG", 32'(SEG), 32'hB0);

    // Blink: two dark frames, two lit frames, repeating.
    blink_en = 1'b1;
    wait_fd();
    for (int f = 0; f < 8; f++) begin
      off_frame[f] = 1;
      for (int k = 0; k < FRAME; k++) begin
        step();
        if (AN !== 4'hF) off_frame[f] = 0;
      end
    end
    begin
      int n_off;
      n_off = 0;
      for (int f = 0; f < 8; f++) n_off += off_frame[f] ? 1 : 0;
      check("blink_off_count", 32'(n_off), 32'd4);
      for (int f = 0; f < 6; f++)
        check("blink_alternate", 32'(off_frame[f] != off_frame[f+2]), 32'h1);
    end
    blink_en = 1'b0;
    wait_fd();
    step();
    check("unblink_AN", 32'(AN), 32'h0E);

    // Reset while a load is pending discards it.
    repeat (3) step();
    do_load(16'h7777, 4'h0);
    check("pre_rst_pend", 32'(pending), 32'h1);
    RST = 1'b1;
    #1;
    check("async_rst_pend", 32'(pending), 32'h0);
    check("async_rst_AN", 32'(AN), 32'h0F);
    check("async_rst_SEG", 32'(SEG), 32'hFF);
    repeat (2) step();
    RST = 1'b0;
    step();
    check("post_rst_d0_AN", 32'(AN), 32'h0E);
    check("post_rst_d0_SEG", 32'(SEG), 32'hC0);
    repeat (CD) step();
    check("post_rst_d1_AN", 32'(AN), 32'h0F);
    wait_fd();
    step();
    check("post_rst_frame_AN", 32'(AN), 32'h0E);
    check("post_rst_frame_SEG", 32'(SEG), 32'hC0);
    check("post_rst_frame_pend", 32'(pending), 32'h0);

    // Randomized traffic checked by the per-cycle model comparison.
    for (int n = 0; n < 900; n++) begin
      logic [15:0] mask;
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      data_in = 16'($urandom) & mask;
      dp_in   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      load    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) blink_en = ~blink_en;
      RST     = ($urandom_range(0, 299) == 0);
      step();
    end
    load = 1'b0;
    RST  = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
